// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e     : E-stage MD op code carried on E_MD_op
//   - md_state_e  : sequencer state
//   - md_cnt_width: width of the busy counter for the configured latencies
//   - md_is_arith : true for ops that occupy the unit (mult/multu/div/divu)
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // Counter must hold the larger of the two latencies.
    function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
        int longest;
        longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(longest + 1);
    endfunction

    function automatic logic md_is_arith(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide datapath on the latched operands.
// Ports:
//   op       in  4   latched MD op (md_op_e encoding)
//   a        in  32  latched rs operand (multiplicand / dividend)
//   b        in  32  latched rt operand (multiplier / divisor)
//   res_hi   out 32  HI result (product high word or remainder)
//   res_lo   out 32  LO result (product low word or quotient)
//   div_zero out 1   div/divu with a zero divisor: result must be discarded
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] divisor;
    logic               div_ovf;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    assign div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);
    // Most negative / -1 does not fit in 32 bits; it is forced to
    // quotient 0x80000000, remainder 0 below.
    assign div_ovf  = (op == MD_DIV) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Keep the dividers away from the zero and overflow cases entirely so the
    // datapath never sees an undefined division.
    assign divisor = (div_zero || div_ovf) ? 32'd1 : b;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};
    // Signed / and % truncate toward zero; remainder takes the dividend's sign.
    assign quot_s = $signed(a) / $signed(divisor);
    assign rem_s  = $signed(a) % $signed(divisor);
    assign quot_u = a / divisor;
    assign rem_u  = a % divisor;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                if (div_ovf) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = quot_s;
                    res_hi = rem_s;
                end
            end
            MD_DIVU: begin
                res_lo = quot_u;
                res_hi = rem_u;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer beside the E-stage ALU.
// Holds HI/LO, runs mult/div over a fixed latency and requests a pipeline
// stall while a later MD instruction waits for the unit.
// Ports:
//   clk      in  1   pipeline clock, rising edge
//   reset    in  1   asynchronous active-low reset
//   E_valid  in  1   E holds a real instruction
//   E_MD_op  in  4   MD op code (md_op_e)
//   E_RS     in  32  forwarded rs operand
//   E_RT     in  32  forwarded rt operand
//   MD_busy  out 1   operation in flight
//   MD_stall out 1   stall request to the hazard unit
//   MD_out   out 32  mfhi/mflo read data
//   HI       out 32  architectural HI
//   LO       out 32  architectural LO
module mdu_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_valid,
    input  logic [3:0]  E_MD_op,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    output logic        MD_busy,
    output logic        MD_stall,
    output logic [31:0] MD_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e          state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [3:0]         op_reg, op_next;
    logic [31:0]        a_reg, a_next;
    logic [31:0]        b_reg, b_next;
    logic [31:0]        hi_reg, hi_next;
    logic [31:0]        lo_reg, lo_next;

    logic               is_md;
    logic               start;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               div_zero;

    md_arith u_arith (
        .op       (op_reg),
        .a        (a_reg),
        .b        (b_reg),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign is_md = E_valid && (E_MD_op != MD_NONE);
    assign start = E_valid && md_is_arith(E_MD_op) && (state_reg == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= MD_NONE;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next    = E_MD_op;
                    a_next     = E_RS;
                    b_next     = E_RT;
                    cnt_next   = ((E_MD_op == MD_MULT) || (E_MD_op == MD_MULTU)) ?
                                 CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_next = BUSY;
                end else if (E_valid && (E_MD_op == MD_MTHI)) begin
                    hi_next = E_RS;
                end else if (E_valid && (E_MD_op == MD_MTLO)) begin
                    lo_next = E_RS;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                    // A zero divisor still burns the full latency but leaves HI/LO alone.
                    if (!div_zero) begin
                        hi_next = res_hi;
                        lo_next = res_lo;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign MD_busy  = (state_reg == BUSY);
    assign MD_stall = is_md && (state_reg == BUSY);
    assign MD_out   = (E_valid && (E_MD_op == MD_MFHI)) ? hi_reg :
                      (E_valid && (E_MD_op == MD_MFLO)) ? lo_reg : 32'd0;
    assign HI       = hi_reg;
    assign LO       = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    import md_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        E_valid = 1'b0;
    logic [3:0]  E_MD_op = 4'd0;
    logic [31:0] E_RS    = 32'd0;
    logic [31:0] E_RT    = 32'd0;
    logic        MD_busy;
    logic        MD_stall;
    logic [31:0] MD_out;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int stall_cnt = 0;

    // Architectural model: HI/LO, cycles of occupancy left, pending result.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    bit          p_wr = 1'b0;
    int          m_left = 0;

    mdu_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_valid  (E_valid),
        .E_MD_op  (E_MD_op),
        .E_RS     (E_RS),
        .E_RT     (E_RT),
        .MD_busy  (MD_busy),
        .MD_stall (MD_stall),
        .MD_out   (MD_out),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0; p_wr = 1'b0; m_left = 0;
    endtask

    // Work out the result the op must eventually produce.
    task automatic model_start(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint      ps;
        logic [63:0] pu;
        int          sa, sb, q, r;
        p_wr = 1'b1;
        case (op)
            MD_MULT: begin
                ps = longint'($signed(rs)) * longint'($signed(rt));
                p_hi = ps[63:32]; p_lo = ps[31:0];
            end
            MD_MULTU: begin
                pu = 64'(rs) * 64'(rt);
                p_hi = pu[63:32]; p_lo = pu[31:0];
            end
            MD_DIV: begin
                sa = int'(rs); sb = int'(rt);
                if (sb == 0) p_wr = 1'b0;
                else if (rs == 32'h8000_0000 && sb == -1) begin p_lo = rs; p_hi = 32'd0; end
                else begin q = sa / sb; r = sa - q * sb; p_lo = q; p_hi = r; end
            end
            default: begin
                if (rt == 32'd0) p_wr = 1'b0;
                else begin p_lo = rs / rt; p_hi = rs % rt; end
            end
        endcase
        m_left = (op == MD_MULT || op == MD_MULTU) ? NM : ND;
    endtask

    // Advance the model across one rising edge, using the inputs held that cycle.
    task automatic model_step();
        if (!reset) return;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (E_valid) begin
            if (md_is_arith(E_MD_op)) model_start(E_MD_op, E_RS, E_RT);
            else if (E_MD_op == MD_MTHI) m_hi = E_RS;
            else if (E_MD_op == MD_MTLO) m_lo = E_RS;
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        E_valid = v; E_MD_op = op; E_RS = rs; E_RT = rt;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, MD_NONE, $urandom, $urandom);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic        exp_stall;
        logic [31:0] exp_out;
        exp_stall = E_valid && (E_MD_op != MD_NONE) && (m_left > 0);
        check("busy", 32'(MD_busy), 32'(m_left > 0));
        check("stall", 32'(MD_stall), 32'(exp_stall));
        check("hi", HI, m_hi);
        check("lo", LO, m_lo);
        if (E_valid && !exp_stall) begin
            exp_out = (E_MD_op == MD_MFHI) ? m_hi : (E_MD_op == MD_MFLO) ? m_lo : 32'd0;
            check("md_out", MD_out, exp_out);
        end
        if (MD_busy) busy_cnt++;
        if (MD_stall) stall_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with an mfhi presented to exercise MD_out.
        E_valid = 1'b1; E_MD_op = MD_MFHI;
        #12;
        check("rst_busy", 32'(MD_busy), 32'd0);
        check("rst_stall", 32'(MD_stall), 32'd0);
        check("rst_out", MD_out, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(2);

        // mult -3 * 5
        busy_cnt = 0;
        drive(1'b1, MD_MULT, 32'hFFFF_FFFD, 32'd5);
        idle(NM + 2);
        check("mult_busy_cycles", busy_cnt, NM);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFF1);
        $display("mult  rs=fffffffd rt=00000005 -> hi=%h lo=%h busy=%0d", HI, LO, busy_cnt);

        // divu 7 / 2
        busy_cnt = 0;
        drive(1'b1, MD_DIVU, 32'd7, 32'd2);
        idle(ND + 2);
        check("divu_busy_cycles", busy_cnt, ND);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);
        $display("divu  rs=00000007 rt=00000002 -> hi=%h lo=%h busy=%0d", HI, LO, busy_cnt);

        // div -7 / 2
        drive(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2);
        idle(ND + 2);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);
        $display("div   rs=fffffff9 rt=00000002 -> hi=%h lo=%h", HI, LO);

        // multu with large operands: 0xFFFFFFFF * 2
        drive(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        idle(NM + 1);
        check("multu_hi", HI, 32'd1);
        check("multu_lo", LO, 32'hFFFF_FFFE);
        $display("multu rs=ffffffff rt=00000002 -> hi=%h lo=%h", HI, LO);

        // mult then dependent mflo held in E
        drive(1'b1, MD_MULT, 32'd6, 32'd7);
        stall_cnt = 0;
        for (int i = 0; i < NM; i++) drive(1'b1, MD_MFLO, 32'd0, 32'd0);
        E_valid = 1'b1; E_MD_op = MD_MFLO;
        @(negedge clk);
        check("mflo_after_stall", 32'(MD_stall), 32'd0);
        check("mflo_value", MD_out, 32'd42);
        @(posedge clk); model_step(); #1;
        check("mflo_stall_cycles", stall_cnt, NM);
        $display("mflo  after mult 6*7 -> md_out=%h stalls=%0d", LO, stall_cnt);

        // mthi while idle
        drive(1'b1, MD_MTHI, 32'h1234, 32'd0);
        check("mthi_idle", HI, 32'h1234);
        $display("mthi  rs=00001234 -> hi=%h", HI);

        // mtlo while busy: stalls, writes only once the unit is free
        drive(1'b1, MD_MULT, 32'd2, 32'd3);
        stall_cnt = 0;
        for (int i = 0; i < NM + 1; i++) drive(1'b1, MD_MTLO, 32'h55, 32'd0);
        idle(1);
        check("mtlo_busy_stalls", stall_cnt, NM);
        check("mtlo_busy_lo", LO, 32'h55);
        check("mtlo_busy_hi", HI, 32'd0);
        $display("mtlo  during mult -> lo=%h stalls=%0d", LO, stall_cnt);

        // back-to-back dependent mult
        drive(1'b1, MD_MULT, 32'd2, 32'd2);
        stall_cnt = 0;
        for (int i = 0; i < NM + 1; i++) drive(1'b1, MD_MULT, 32'd3, 32'd3);
        idle(NM + 1);
        check("b2b_stalls", stall_cnt, NM);
        check("b2b_lo", LO, 32'd9);
        $display("mult  back-to-back 3*3 -> lo=%h stalls=%0d", LO, stall_cnt);

        // divide by zero leaves preloaded HI/LO
        drive(1'b1, MD_MTHI, 32'hA, 32'd0);
        drive(1'b1, MD_MTLO, 32'hB, 32'd0);
        busy_cnt = 0;
        drive(1'b1, MD_DIV, 32'd5, 32'd0);
        idle(ND + 2);
        check("div0_busy_cycles", busy_cnt, ND);
        check("div0_hi", HI, 32'hA);
        check("div0_lo", LO, 32'hB);
        $display("div   rs=00000005 rt=00000000 -> hi=%h lo=%h busy=%0d", HI, LO, busy_cnt);

        // signed overflow case
        drive(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(ND + 1);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 32'd0);
        $display("div   rs=80000000 rt=ffffffff -> hi=%h lo=%h", HI, LO);

        // reset during cycle 3 of a div
        drive(1'b1, MD_DIV, 32'd100, 32'd7);
        idle(2);
        reset = 1'b0;
        model_clear();
        #1;
        check("abort_busy", 32'(MD_busy), 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        $display("reset during div -> busy=%0d hi=%h lo=%h", MD_busy, HI, LO);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        idle(1);
        drive(1'b1, MD_MULT, 32'd3, 32'd4);
        idle(NM + 1);
        check("post_rst_lo", LO, 32'd12);
        check("post_rst_hi", HI, 32'd0);
        $display("mult  after reset 3*4 -> hi=%h lo=%h", HI, LO);

        // bubbles ignore their op field
        drive(1'b0, MD_MTHI, 32'hDEAD, 32'd0);
        drive(1'b0, MD_MULT, 32'd9, 32'd9);
        idle(1);
        check("bubble_hi", HI, 32'd0);
        check("bubble_lo", LO, 32'd12);
        $display("bubbles with mthi/mult -> hi=%h lo=%h", HI, LO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer for the five-stage pipeline. It sits beside the ALU in the E stage and accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo from E. It holds HI/LO, computes the product or quotient over a fixed number of cycles, and raises a stall request so the hazard unit freezes F/D/E and bubbles E_M while a dependent MD instruction waits.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- E_valid  in  1  E holds a real instruction (not a bubble)
- E_MD_op  in  4  md_pkg op code: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO
- E_RS  in  32  forwarded rs operand
- E_RT  in  32  forwarded rt operand
- MD_busy  out  1  operation in flight
- MD_stall  out  1  stall request to hazard unit
- MD_out  out  32  mfhi/mflo read data, muxed into E result
- HI  out  32  architectural HI
- LO  out  32  architectural LO

## Operation
- States: IDLE, BUSY. `MD_busy` = (state==BUSY).
- `is_md` = E_valid && E_MD_op != MD_NONE.
- `start` = E_valid && op ∈ {MULT, MULTU, DIV, DIVU} && state==IDLE.
- `MD_stall` = is_md && state==BUSY. Combinational, from registered state only. The starting instruction itself never stalls.
- On start edge:
  - latch op, E_RS, E_RT
  - load counter with MULT_CYCLES or DIV_CYCLES
  - go to BUSY
- In BUSY, counter decrements each edge. On the edge where counter==1:
  - write HI/LO
  - go to IDLE
- Results:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - Divisor 0 (div or divu): HI/LO unchanged, busy for the full DIV_CYCLES.
- mthi/mtlo in IDLE and E_valid: HI or LO = E_RS at that edge. In BUSY they stall; no write.
- `MD_out`:
  - HI when op==MFHI, LO when op==MFLO, else 0.
  - Reads current registered HI/LO.
  - Only meaningful when not stalled.
- E_valid=0 ignores E_MD_op entirely.

## Timing
- Reset (async, low): state=IDLE, counter=0, HI=0, LO=0, latched operands=0. Outputs: MD_busy=0, MD_stall=0, MD_out=0.
- Reset mid-operation aborts immediately with no HI/LO write. After release, the block is IDLE.
- Start at edge T:
  - MD_busy=1 during cycles T+1 … T+N (N = configured latency).
  - HI/LO update at edge T+N.
  - MD_busy=0 from cycle T+N+1.
- A dependent mf/mt/mult in E at T+1 stalls N cycles and proceeds in cycle T+N+1, reading the new HI/LO.
- Back-to-back MD ops with no dependency gap stall identically.
- Non-MD instructions never stall.
- MD_stall goes high in the same cycle the waiting instruction appears in E (combinational on E_MD_op).

## Structure
- `md_pkg`: E_MD_op encoding constants; state enum; counter width = $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Sub-module `md_arith`: purely combinational signed/unsigned mult and div of the latched operands, including the divide-by-zero flag and the overflow special case.
- `mdu_ctrl` owns the FSM, counter, operand latches and HI/LO.

## Test plan
- Default params. mult, E_RS=0xFFFFFFFD (-3), E_RT=5 → MD_busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- divu, E_RS=7, E_RT=2 → busy 10 cycles; then LO=3, HI=1. div, E_RS=-7, E_RT=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mult at T with mflo held in E from T+1 → MD_stall=1 for T+1..T+5. In T+6: MD_stall=0 and MD_out equals the new LO.
- mthi 0x1234 while IDLE → HI=0x1234 next cycle. mtlo while BUSY → stalls; LO takes the value only after busy ends.
- div with E_RT=0 and HI/LO preloaded to 0xA/0xB → busy 10 cycles; HI/LO remain 0xA/0xB. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Assert reset at cycle 3 of a div → MD_busy=0 and HI=LO=0 immediately. A new mult after release completes normally.
